// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state enum, default width and counter sizing for the
// serializer and the downstream shift register that consumes its stream.
package piso_serializer_pkg;

    typedef enum logic {IDLE, SHIFT} state_e;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: bit index within a word; clears on load, wraps after WIDTH-1
// so it never leaves the 0..WIDTH-1 range.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o  = cnt_q == CW'(WIDTH - 1);
    assign cnt_o = cnt_q;
    assign cnt_d = (load_i || (inc_i && tc_o)) ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out with valid/ready intake, framing and
// last-bit flag; words can be streamed back-to-back without a gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sout,
    output logic             sframe,
    output logic             last_bit
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             sframe_q, last_q;
    logic [CW-1:0]    cnt;
    logic             tc, accept;

    piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .inc_i  (state_q == SHIFT),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    assign in_ready = !rst && (state_q == IDLE || tc);
    assign accept   = in_valid && in_ready;
    // Zeros shift in behind the data, so the register is empty once a word drains.
    assign sreg_d   = (MSB_FIRST != 0) ? sreg_q << 1 : sreg_q >> 1;
    assign sout     = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sframe   = sframe_q;
    assign last_bit = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            sframe_q <= 1'b0;
            last_q   <= 1'b0;
        end else if (accept) begin
            state_q  <= SHIFT;
            sreg_q   <= in_data;
            sframe_q <= 1'b1;
            last_q   <= 1'b0;
        end else if (state_q == SHIFT) begin
            sreg_q   <= sreg_d;
            last_q   <= cnt == CW'(WIDTH - 2);
            if (tc) begin
                state_q  <= IDLE;
                sframe_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: MSB-first and LSB-first instances share one stimulus stream;
// a queue-based scoreboard checks every framed bit plus the idle/ready behaviour.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       rdy_m, sout_m, sframe_m, last_m;
    logic       rdy_l, sout_l, sframe_l, last_l;
    logic [3:0] dsr = 4'b0;
    logic [1:0] qm[$];
    logic [1:0] ql[$];
    int         errors = 0;
    int         checks = 0;
    int         run = 0;
    int         last_run = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_m), .sout(sout_m), .sframe(sframe_m), .last_bit(last_m)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_l), .sout(sout_l), .sframe(sframe_l), .last_bit(last_l)
    );

    // Downstream 4-bit shift register fed by the MSB-first stream.
    always @(posedge clk) if (sframe_m) dsr <= {dsr[2:0], sout_m};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] em, el;
        chk("sframe_m", sframe_m, qm.size() != 0);
        chk("sframe_l", sframe_l, ql.size() != 0);
        if (qm.size() != 0 && ql.size() != 0) begin
            em = qm.pop_front();
            el = ql.pop_front();
            chk("sout_m", sout_m, em[1]);
            chk("last_m", last_m, em[0]);
            chk("sout_l", sout_l, el[1]);
            chk("last_l", last_l, el[0]);
            chk("ready_busy", rdy_m, !rst && em[0]);
            chk("ready_busy_l", rdy_l, !rst && el[0]);
        end else begin
            chk("idle_sout_m", sout_m, 1'b0);
            chk("idle_last_m", last_m, 1'b0);
            chk("idle_sout_l", sout_l, 1'b0);
            chk("idle_last_l", last_l, 1'b0);
            chk("ready_idle", rdy_m, !rst);
        end
        if (sframe_m) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    task automatic send(input logic [3:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!rdy_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_m) begin
            chk("accept_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            qm.push_back({w[3-i], i == 3});
            ql.push_back({w[i], i == 3});
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 4'b0;
        idle(2);
        chk("rst_sframe", sframe_m, 1'b0);
        chk("rst_sout", sout_m, 1'b0);
        chk("rst_last", last_m, 1'b0);
        chk("rst_ready", rdy_m, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", rdy_m, 1'b1);

        send(4'b1011);
        idle(6);
        chk("e2e_dsr", dsr, 4'b1011);

        send(4'b1010);
        send(4'b0110);
        idle(8);
        chk("gapless_run", last_run, 8);

        send(4'b0001);
        idle(6);

        send(4'b1111);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        qm.delete();
        ql.delete();
        chk("midrst_sframe", sframe_m, 1'b0);
        chk("midrst_sout", sout_m, 1'b0);
        chk("midrst_last", last_m, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", rdy_m, 1'b1);
        idle(3);

        send(4'b1111);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 4'b0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(8);

        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 4'b1111;
        idle(1);
        rst = 1'b0;
        in_valid = 1'b0;
        idle(6);
        chk("rst_accept_sframe", sframe_m, 1'b0);
        chk("queue_drained", qm.size() + ql.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 in_valid  input  1: upstream presents a word on in_data.
REQ-006 in_data  input  WIDTH: parallel word to serialise.
REQ-007 in_ready  output  1: block accepts in_data this cycle.
REQ-008 sout  output  1: serial bit stream; drives the downstream shift register D input.
REQ-009 sframe  output  1: high while sout carries a valid data bit.
REQ-010 last_bit  output  1: high during the final bit of each word.

Function
REQ-011 A transfer is accepted on a rising edge where in_valid=1 and in_ready=1; in_data is captured into an internal shift register.
REQ-012 The FSM shall have two states: IDLE and SHIFT.
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT on accept during the last bit.
  - SHIFT -> IDLE at the end of the last bit with no accept.
REQ-013 in_ready shall be 1 in IDLE and during the last-bit cycle of SHIFT; otherwise 0, and forced 0 while rst=1.
REQ-014 Latency: the first bit of an accepted word appears on sout in the cycle immediately after the accept edge.
REQ-015 Each word occupies exactly WIDTH consecutive cycles with sframe=1, one bit per cycle, in the order set by MSB_FIRST.
REQ-016 A bit counter (width clog2(WIDTH)) shall count 0..WIDTH-1 in SHIFT, reset to 0 on every accept, and never exceed WIDTH-1.
REQ-017 last_bit shall be 1 exactly when state=SHIFT and counter=WIDTH-1.
REQ-018 An accept during the last-bit cycle shall give gapless output: the next word's first bit follows the previous last bit with sframe held at 1.
REQ-019 in_valid and in_data are ignored while in_ready=0; the captured word shall not change mid-shift.
REQ-020 In IDLE, sout shall be 0 and sframe shall be 0.
REQ-021 in_data changing after the accept edge shall have no effect on the word in flight.

Reset
REQ-022 On a rising edge with rst=1, the following shall hold on the next cycle:
  - state=IDLE, counter=0, shift register=0;
  - sout=0, sframe=0, last_bit=0.
REQ-023 Reset asserted mid-word shall discard the remaining bits, with no partial completion.
REQ-024 in_ready shall return to 1 in the first cycle after rst deasserts.
REQ-025 Simultaneous rst=1 and accept: reset wins and the word is dropped.

Structure
REQ-026 A shared package shall hold:
  - the state enum (IDLE, SHIFT);
  - default WIDTH;
  - the counter-width function/constant;
  - for reuse with the downstream shift register and its bench.
REQ-027 One sub-module is natural: piso_bit_counter (load-to-zero, increment, terminal-count flag); everything else stays in piso_serializer.
REQ-028 All outputs shall be registered except in_ready, which is decoded from state, counter and rst.

Verification
REQ-029 Single word, WIDTH=4, MSB_FIRST=1, in_data=4'b1011 accepted at cycle 0 -> cycles 1..4:
  - sout=1,0,1,1;
  - sframe=1 for those four cycles;
  - last_bit=1 at cycle 4 only;
  - in_ready=0 at cycles 1..3.
REQ-030 Back-to-back 4'b1010 then 4'b0110 with in_valid held -> eight contiguous sframe=1 cycles with sout=1,0,1,0,0,1,1,0, and last_bit at cycles 4 and 8.
REQ-031 MSB_FIRST=0, in_data=4'b0001 -> sout=1,0,0,0.
REQ-032 Reset mid-word: accept 4'b1111, assert rst after 2 bits -> the cycle after the reset edge has sframe=0 and sout=0, and in_ready=1 the cycle after rst deasserts.
REQ-033 in_valid pulsed with 4'b0000 at cycle 2 of an in-flight 4'b1111 word -> the pulse is ignored and sout stays 1 for all four bits.
REQ-034 End-to-end: serializer feeding the 4-bit shift register -> after 4 bits of 4'b1011, the register's parallel contents equal 1011 (MSB_FIRST=1).
